// File: rtl/mc_control_pkg.sv
// Shared definitions for the multi-cycle RV32I-subset control path: ALU opcodes,
// instruction opcodes and the controller state encoding.
package mc_control_pkg;

   // ALU opcode encoding, shared with the datapath ALU
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [2:0] {
      S_IF, S_ID, S_EX, S_MEM, S_WB, S_ERR
   } state_t;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// Combinational decode of opcode/funct3/funct7[5] into the ALU opcode, the
// ALU B-operand select and an illegal-instruction flag.
module mc_control_alu_decoder
   import mc_control_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output logic [3:0] alu_op,
   output logic       alu_src,
   output logic       illegal
);

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      alu_op  = ALU_ADD;
      alu_src = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            alu_src = (opcode == OP_I);
            case (funct3)
               3'b000: alu_op = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
               3'b001: alu_op = ALU_SLL;
               3'b010: alu_op = ALU_SLT;
               3'b100: alu_op = ALU_XOR;
               3'b101: alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
               3'b110: alu_op = ALU_OR;
               3'b111: alu_op = ALU_AND;
               default: illegal = 1'b1;
            endcase
         end
         OP_LW, OP_SW: begin
            alu_src = 1'b1;
            illegal = (funct3 != 3'b010);
         end
         OP_BEQ: begin
            alu_op  = ALU_SUB;
            illegal = (funct3 != 3'b000);
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle IF/ID/EX/MEM/WB controller with a bounded data-memory wait and a
// sticky error state. Define MC_CONTROL_PERF_EN to add instret/stall_cycles counters.
module mc_control
   import mc_control_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        dmem_ready,
   output logic        ir_write,
   output logic [3:0]  alu_op,
   output logic        alu_src,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        load_pc,
   output logic        pc_src,
   output logic        error
`ifdef MC_CONTROL_PERF_EN
   ,
   output logic [31:0] instret,
   output logic [31:0] stall_cycles
`endif
);

   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   state_t     state;
   logic [7:0] wait_cnt;
   logic [3:0] dec_alu_op;
   logic       dec_alu_src;
   logic       dec_illegal;
   logic       is_lw, is_sw, is_beq;
   logic       unused_instr;

   assign is_lw        = (instr[6:0] == OP_LW);
   assign is_sw        = (instr[6:0] == OP_SW);
   assign is_beq       = (instr[6:0] == OP_BEQ);
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   mc_control_alu_decoder u_dec (
      .opcode   (instr[6:0]),
      .funct3   (instr[14:12]),
      .funct7_5 (instr[30]),
      .alu_op   (dec_alu_op),
      .alu_src  (dec_alu_src),
      .illegal  (dec_illegal)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IF;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_IF: state <= S_ID;
            S_ID: state <= dec_illegal ? S_ERR : S_EX;
            S_EX: begin
               if (is_lw || is_sw) begin
                  state    <= S_MEM;
                  wait_cnt <= '0;
               end else if (is_beq) begin
                  state <= S_IF;
               end else begin
                  state <= S_WB;
               end
            end
            // Ready is tested first so a completion on the last permitted cycle wins.
            S_MEM: begin
               if (dmem_ready)                state    <= is_lw ? S_WB : S_IF;
               else if (wait_cnt == WAIT_LAST) state   <= S_ERR;
               else                           wait_cnt <= wait_cnt + 8'd1;
            end
            S_WB:    state <= S_IF;
            default: state <= S_ERR;
         endcase
      end
   end

   always_comb begin
      ir_write   = 1'b0;
      alu_op     = ALU_ADD;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      load_pc    = 1'b0;
      pc_src     = 1'b0;
      error      = 1'b0;
      case (state)
         S_IF: ir_write = 1'b1;
         S_EX: begin
            alu_op  = dec_alu_op;
            alu_src = dec_alu_src;
            if (is_beq) begin
               load_pc = 1'b1;
               pc_src  = zero;
            end
         end
         S_MEM: begin
            mem_read  = is_lw;
            mem_write = is_sw;
            load_pc   = is_sw && dmem_ready;
         end
         S_WB: begin
            reg_write  = 1'b1;
            load_pc    = 1'b1;
            mem_to_reg = is_lw;
         end
         S_ERR:   error = 1'b1;
         default: ;
      endcase
   end

`ifdef MC_CONTROL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         instret      <= '0;
         stall_cycles <= '0;
      end else if (state != S_ERR) begin
         if (load_pc)                     instret      <= instret + 32'd1;
         if (state == S_MEM && !dmem_ready) stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule
